// File: rtl/ssd_scan_driver.sv
// Seven-segment scan driver: sequential double-dabble BCD conversion into a tear-free snapshot,
// multiplexed over NUM_DIGITS active-low anodes. Define SSD_LZ_BLANK_EN for leading-zero blanking.
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    value,
  output logic [6:0]            ssdOut,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  conv_busy,
  output logic                  overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [VALUE_W-1:0] shreg;
  logic [BCD_W-1:0]   bcd, bcd_adj;
  logic               ovf_acc;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   snap;
  logic               ovf_snap;
  logic [REF_W-1:0]   ref_cnt;
  logic [IDX_W-1:0]   idx;
  logic [3:0]         cur_digit;
  logic [6:0]         seg_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    conv_busy  = 1'b0;
    case (state)
      IDLE:  state_next = SHIFT;
      SHIFT: begin
        conv_busy = 1'b1;
        if (bit_cnt == CNT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: nibbles of 5 or more become >= 8 so the shift carries into the next digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      bcd      <= '0;
      ovf_acc  <= 1'b0;
      bit_cnt  <= '0;
      snap     <= '0;
      ovf_snap <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          shreg   <= value;
          bcd     <= '0;
          ovf_acc <= 1'b0;
          bit_cnt <= CNT_W'(VALUE_W);
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
          ovf_acc      <= ovf_acc | bcd_adj[BCD_W-1];
          bit_cnt      <= bit_cnt - CNT_W'(1);
        end
        DONE: begin
          snap     <= bcd;
          ovf_snap <= ovf_acc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      if (NUM_DIGITS == 1 || idx == IDX_W'(NUM_DIGITS - 1)) idx <= '0;
      else                                                  idx <= idx + IDX_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

`ifdef SSD_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic                  cur_lz;

  // A digit is a leading zero when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (snap[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end
`endif

  always_comb begin
    cur_digit = '0;
`ifdef SSD_LZ_BLANK_EN
    cur_lz    = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit = snap[4*i +: 4];
`ifdef SSD_LZ_BLANK_EN
        cur_lz    = lead_zero[i];
`endif
      end
    end
  end

  always_comb begin
    if (ovf_snap) seg_next = SEG_DASH;
`ifdef SSD_LZ_BLANK_EN
    else if (cur_lz) seg_next = SEG_BLANK;
`endif
    else seg_next = seg_decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anode  <= '1;
      ssdOut <= SEG_BLANK;
    end else begin
      anode  <= ~(NUM_DIGITS'(1) << idx);
      ssdOut <= seg_next;
    end
  end

  assign overflow = ovf_snap;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a short refresh period so whole scan frames are observable.
module tb_ssd_scan_driver;

  localparam int ND = 4;
  localparam int VW = 16;
  localparam int RD = 4;

  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic          clk = 1'b0;
  logic          reset;
  logic [VW-1:0] value;
  logic [6:0]    ssdOut;
  logic [ND-1:0] anode;
  logic          conv_busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  ssd_scan_driver #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .ssdOut    (ssdOut),
    .anode     (anode),
    .conv_busy (conv_busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b0000001;
      1: seg_of = 7'b1001111;
      2: seg_of = 7'b0010010;
      3: seg_of = 7'b0000110;
      4: seg_of = 7'b1001100;
      5: seg_of = 7'b0100100;
      6: seg_of = 7'b0100000;
      7: seg_of = 7'b0001111;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0000100;
      default: seg_of = BLANK;
    endcase
  endfunction

`ifdef SSD_LZ_BLANK_EN
  localparam logic [6:0] LZ = BLANK;
`else
  localparam logic [6:0] LZ = 7'b0000001;
`endif

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_anode(input string tag, input logic [ND-1:0] pat);
    int n;
    n = 0;
    while (anode !== pat && n < 64) begin
      step(1);
      n++;
    end
    check(tag, 32'(anode), 32'(pat));
  endtask

  task automatic wait_busy_rise(input string tag);
    logic prev;
    int   n;
    prev = conv_busy;
    n    = 0;
    while (n < 64) begin
      step(1);
      n++;
      if (conv_busy && !prev) break;
      prev = conv_busy;
    end
    check(tag, 32'(conv_busy), 32'd1);
  endtask

  // Samples 16 consecutive cycles; exp_seg[i] is the required pattern while digit i is lit.
  task automatic check_frame(input string tag, input logic [ND-1:0][6:0] exp_seg);
    int k;
    for (int c = 0; c < 16; c++) begin
      k = -1;
      for (int i = 0; i < ND; i++) if (anode === ~(ND'(1) << i)) k = i;
      if (k < 0) check({tag, "_anode"}, 32'(anode), 32'(4'b1110));
      else       check(tag, 32'(ssdOut), 32'(exp_seg[k]));
      step(1);
    end
  endtask

  // Called one cycle into reset with value already set; releases and checks conversion timing.
  task automatic release_and_check(input string tag, input logic [6:0] new_d0);
    reset = 1'b0;
    step(1);
    check({tag, "_busy1"},  32'(conv_busy), 32'd1);
    check({tag, "_anode1"}, 32'(anode), 32'(4'b1110));
    check({tag, "_seg1"},   32'(ssdOut), 32'(seg_of(0)));
    step(15);
    check({tag, "_busy16"}, 32'(conv_busy), 32'd1);
    step(1);
    check({tag, "_busy17"}, 32'(conv_busy), 32'd0);
    step(1);
    check({tag, "_anode18"}, 32'(anode), 32'(4'b1110));
    check({tag, "_seg18"},   32'(ssdOut), 32'(seg_of(0)));
    check({tag, "_ovf18"},   32'(overflow), 32'd0);
    step(1);
    check({tag, "_seg19"},  32'(ssdOut), 32'(new_d0));
    check({tag, "_busy19"}, 32'(conv_busy), 32'd1);
  endtask

  logic [3:0][ND-1:0] seq_anode;
  logic [3:0][6:0]    seq_seg;

  initial begin
    reset = 1'b1;
    value = 16'd9999;
    step(3);
    check("rst_anode", 32'(anode), 32'(4'b1111));
    check("rst_seg",   32'(ssdOut), 32'(7'b1111111));
    check("rst_busy",  32'(conv_busy), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    release_and_check("start", seg_of(9));

    // 1234 scanned right to left, four cycles per digit
    value = 16'd1234;
    step(40);
    seq_anode = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    seq_seg   = {seg_of(1), seg_of(2), seg_of(3), seg_of(4)};
    wait_anode("sync_d3", 4'b0111);
    wait_anode("sync_d0", 4'b1110);
    for (int c = 0; c < 16; c++) begin
      check($sformatf("scan_anode_%0d", c), 32'(anode), 32'(seq_anode[c/4]));
      check($sformatf("scan_seg_%0d", c),   32'(ssdOut), 32'(seq_seg[c/4]));
      step(1);
    end
    check("scan_wrap", 32'(anode), 32'(4'b1110));

    value = 16'd65535;
    step(40);
    check("ovf_set", 32'(overflow), 32'd1);
    check_frame("ovf_dash", {DASH, DASH, DASH, DASH});

    value = 16'd7;
    step(40);
    check("ovf_clr", 32'(overflow), 32'd0);
    check_frame("val7", {LZ, LZ, LZ, seg_of(7)});

    value = 16'd0;
    step(40);
    check_frame("val0", {LZ, LZ, LZ, seg_of(0)});

    value = 16'd1005;
    step(40);
    check_frame("val1005", {seg_of(1), seg_of(0), seg_of(0), seg_of(5)});

    // value changes during the 5th shift cycle; that conversion must still show 100
    value = 16'd100;
    wait_busy_rise("mid_sync");
    step(4);
    value = 16'd200;
    step(14);
    check_frame("mid_100", {LZ, seg_of(1), seg_of(0), seg_of(0)});
    step(20);
    check_frame("mid_200", {LZ, seg_of(2), seg_of(0), seg_of(0)});

    // reset pulse during shift clears an overflowed snapshot
    value = 16'd65535;
    step(40);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    wait_busy_rise("rst_sync");
    step(3);
    reset = 1'b1;
    value = 16'd9999;
    step(1);
    check("midrst_anode", 32'(anode), 32'(4'b1111));
    check("midrst_seg",   32'(ssdOut), 32'(7'b1111111));
    check("midrst_busy",  32'(conv_busy), 32'd0);
    check("midrst_ovf",   32'(overflow), 32'd0);
    release_and_check("restart", seg_of(9));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
